// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared opcodes, FSM states, access sizes and opcode decode for the LSU
package lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'd0;
    localparam logic [5:0] OP_LH  = 6'd1;
    localparam logic [5:0] OP_LW  = 6'd2;
    localparam logic [5:0] OP_LBU = 6'd3;
    localparam logic [5:0] OP_LHU = 6'd4;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    typedef struct packed {
        logic      legal;
        logic      store;
        logic      sext;
        lsu_size_e size;
    } lsu_dec_t;

    function automatic lsu_dec_t lsu_decode(input logic [5:0] op);
        lsu_dec_t d;
        d.legal = 1'b1;
        d.store = 1'b0;
        d.sext  = 1'b0;
        d.size  = SZ_WORD;
        case (op)
            OP_LB:   begin d.sext = 1'b1; d.size = SZ_BYTE; end
            OP_LH:   begin d.sext = 1'b1; d.size = SZ_HALF; end
            OP_LW:   d.size = SZ_WORD;
            OP_LBU:  d.size = SZ_BYTE;
            OP_LHU:  d.size = SZ_HALF;
            OP_SB:   begin d.store = 1'b1; d.size = SZ_BYTE; end
            OP_SH:   begin d.store = 1'b1; d.size = SZ_HALF; end
            OP_SW:   begin d.store = 1'b1; d.size = SZ_WORD; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane select, load extension and store replication
// Ports: size/sext/addr_lo describe the access; wdata is the store source, rdata
// the bus read word; be, wdata_rep and rdata_ext are the lane-aligned results.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        sext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        case (addr_lo)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sext & rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sext & rhalf[15]}}, rhalf};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller: request FSM, access latches, bus timeout
// Ports: core side req_* in / rsp_* out, bus side mem_* out / mem_gnt, mem_rvalid,
// mem_rdata, mem_err in, busy out. Parameter TIMEOUT_CYC bounds the WAIT state.
// Build option MISALIGN_TRAP_EN: misaligned half/word accesses fail without touching
// the bus; otherwise the low address bits are cleared and the access proceeds.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    lsu_state_e       state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] req_addr_al;
    logic        misalign;
    logic        reject;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    // The latched address is always naturally aligned, so the aligner never sees
    // offending low bits regardless of the trap option.
    always_comb begin
        req_addr_al = req_addr;
        misalign    = 1'b0;
        case (lsu_decode(req_op).size)
            SZ_HALF: begin
                misalign       = req_addr[0];
                req_addr_al[0] = 1'b0;
            end
            SZ_WORD: begin
                misalign         = |req_addr[1:0];
                req_addr_al[1:0] = 2'b00;
            end
            default: ;
        endcase
        reject = !lsu_decode(req_op).legal || (TRAP_EN && misalign);
    end

    lsu_align u_align (
        .size      (lsu_decode(op_q).size),
        .sext      (lsu_decode(op_q).sext),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr_al;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = reject;
                    state_d = reject ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // rvalid is checked first so a response on the last allowed cycle wins.
                if (mem_rvalid) begin
                    state_d = ST_RESP;
                    err_d   = mem_err;
                    rdata_d = (mem_err || lsu_decode(op_q).store) ? 32'h0 : al_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus and response outputs are gated by state so they read 0 whenever unused.
    assign busy      = (state_q != ST_IDLE);
    assign req_ready = !busy;
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_req && lsu_decode(op_q).store;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be    = mem_req ? al_be : 4'h0;
    assign mem_wdata = mem_we ? al_wdata : 32'h0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl: vector table, reset sequence, random vs model
module tb_lsu_ctrl;

    localparam int TO = 16;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_err = 1'b0;
    logic        busy;

    lsu_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        merr;
        int          gnt_dly;
        int          rv_dly;
        logic        bus;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
    } vec_t;

    function automatic vec_t mkv(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic merr, input int gd, input int rd,
                                 input logic bus, input logic we, input logic [31:0] maddr, input logic [3:0] be,
                                 input logic [31:0] mwdata, input logic [31:0] er, input logic ee, input int lat);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.merr = merr;
        v.gnt_dly = gd; v.rv_dly = rd; v.bus = bus; v.we = we; v.maddr = maddr; v.be = be;
        v.mwdata = mwdata; v.exp_rdata = er; v.exp_err = ee; v.lat = lat;
        return v;
    endfunction

    // Reference behaviour from the access rules, using byte arithmetic only.
    function automatic vec_t model(input vec_t v);
        vec_t   e;
        int     size;
        bit     sgn;
        int     off;
        longint mask;
        longint val;
        logic [31:0] a;
        bit     timed_out;
        e = v;
        sgn = 0;
        case (int'(v.op))
            0:  begin size = 1; sgn = 1; end
            1:  begin size = 2; sgn = 1; end
            2:  size = 4;
            3:  size = 1;
            4:  size = 2;
            15: size = 1;
            16: size = 2;
            17: size = 4;
            default: size = 0;
        endcase
        e.we = (int'(v.op) >= 15);
        e.maddr = 0; e.be = 0; e.mwdata = 0;
        if (size == 0 || (TRAP && (v.addr % size) != 0)) begin
            e.bus = 0; e.exp_err = 1; e.exp_rdata = 0; e.lat = 1;
            return e;
        end
        e.bus = 1;
        a = v.addr - (v.addr % size);
        off = int'(a % 4);
        e.maddr = a - off;
        e.be = 4'(((1 << size) - 1) << off);
        if (size == 1)      e.mwdata = (v.wdata & 32'hFF) * 32'h0101_0101;
        else if (size == 2) e.mwdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
        else                e.mwdata = v.wdata;
        timed_out = (v.rv_dly >= TO);
        e.lat = 2 + v.gnt_dly + (timed_out ? TO : v.rv_dly + 1);
        e.exp_err = timed_out || v.merr;
        if (e.exp_err || e.we) e.exp_rdata = 0;
        else begin
            mask = (64'd1 << (8 * size)) - 1;
            val = (longint'(v.rdata) >> (8 * off)) & mask;
            if (sgn && val[8 * size - 1]) val = val | (~mask & 64'hFFFF_FFFF);
            e.exp_rdata = val[31:0];
        end
        return e;
    endfunction

    task automatic run_txn(input vec_t v, input bit noise, input string tag);
        int req_seen = 0;
        int wait_seen = 0;
        bit granted = 0;
        bit done = 0;
        bit saw_req = 0;
        bit stable = 1;
        bit flow_ok = 1;
        int lat = -1;
        logic [31:0] s_addr = 0, s_wdata = 0, g_rdata = 0;
        logic [3:0]  s_be = 0;
        logic        s_we = 0, g_err = 0;
        @(negedge clk);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0; req_op = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 60 && !done; k++) begin
            if (!busy || req_ready) flow_ok = 0;
            if (rsp_valid) begin
                lat = k; g_rdata = rsp_rdata; g_err = rsp_err; done = 1;
                mem_gnt = 0; mem_rvalid = 0;
            end else if (mem_req) begin
                if (!saw_req) begin
                    s_addr = mem_addr; s_be = mem_be; s_we = mem_we; s_wdata = mem_wdata;
                end else if (s_addr !== mem_addr || s_be !== mem_be || s_we !== mem_we || s_wdata !== mem_wdata) begin
                    stable = 0;
                end
                saw_req = 1;
                req_seen++;
                mem_gnt = (req_seen > v.gnt_dly);
                granted = mem_gnt;
                mem_rvalid = noise ? 1'($urandom) : 1'b0;
                mem_rdata = $urandom; mem_err = 1'($urandom);
            end else if (granted) begin
                wait_seen++;
                mem_rvalid = (wait_seen > v.rv_dly);
                mem_rdata = mem_rvalid ? v.rdata : $urandom;
                mem_err = mem_rvalid ? v.merr : 1'($urandom);
                mem_gnt = noise ? 1'($urandom) : 1'b0;
            end else begin
                mem_gnt = 0; mem_rvalid = 0;
            end
            if (!done) @(negedge clk);
        end
        chk({tag, ".lat"}, 32'(lat), 32'(v.lat));
        chk({tag, ".rdata"}, g_rdata, v.exp_rdata);
        chk({tag, ".err"}, 32'(g_err), 32'(v.exp_err));
        chk({tag, ".bus_used"}, 32'(saw_req), 32'(v.bus));
        chk({tag, ".busy_flow"}, 32'(flow_ok), 32'd1);
        if (v.bus) begin
            chk({tag, ".mem_addr"}, s_addr, v.maddr);
            chk({tag, ".mem_be"}, 32'(s_be), 32'(v.be));
            chk({tag, ".mem_we"}, 32'(s_we), 32'(v.we));
            chk({tag, ".stable"}, 32'(stable), 32'd1);
            if (v.we) chk({tag, ".mem_wdata"}, s_wdata, v.mwdata);
        end
        @(negedge clk);
        chk({tag, ".one_cycle"}, {30'd0, rsp_valid, busy}, 32'd0);
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = mkv(6'd0,  32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0,  1, 0, 32'h100, 4'b1000, 0, 32'hFFFF_FF80, 0, 3);
        tbl[1]  = mkv(6'd16, 32'h202, 32'h0000_ABCD, 0, 0, 0, 0,    1, 1, 32'h200, 4'b1100, 32'hABCD_ABCD, 0, 0, 3);
        tbl[2]  = mkv(6'd2,  32'h040, 0, 32'hDEAD_BEEF, 0, 5, 0,     1, 0, 32'h040, 4'b1111, 0, 32'hDEAD_BEEF, 0, 8);
        tbl[3]  = mkv(6'd4,  32'h012, 0, 32'h1234_5678, 0, 0, 99,   1, 0, 32'h010, 4'b1100, 0, 0, 1, 18);
        tbl[4]  = mkv(6'd4,  32'h012, 0, 32'h8765_4321, 0, 0, 15,   1, 0, 32'h010, 4'b1100, 0, 32'h0000_8765, 0, 18);
        tbl[6]  = mkv(6'd5,  32'h000, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 0, 1, 1);
        tbl[7]  = mkv(6'd15, 32'h001, 32'h0000_00A5, 0, 1, 0, 0,    1, 1, 32'h000, 4'b0010, 32'hA5A5_A5A5, 0, 1, 3);
        tbl[8]  = mkv(6'd1,  32'h000, 0, 32'h0000_F00D, 0, 0, 0,    1, 0, 32'h000, 4'b0011, 0, 32'hFFFF_F00D, 0, 3);
        tbl[9]  = mkv(6'd3,  32'h002, 0, 32'h00AB_0000, 0, 0, 0,    1, 0, 32'h000, 4'b0100, 0, 32'h0000_00AB, 0, 3);
        tbl[10] = mkv(6'd17, 32'h008, 32'h1234_5678, 0, 0, 0, 0,   1, 1, 32'h008, 4'b1111, 32'h1234_5678, 0, 0, 3);
`ifdef MISALIGN_TRAP_EN
        tbl[5]  = mkv(6'd2,  32'h101, 0, 32'h1122_3344, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 1);
        tbl[11] = mkv(6'd1,  32'h003, 0, 32'h8001_0000, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 1);
`else
        tbl[5]  = mkv(6'd2,  32'h101, 0, 32'h1122_3344, 0, 0, 0,    1, 0, 32'h100, 4'b1111, 0, 32'h1122_3344, 0, 3);
        tbl[11] = mkv(6'd1,  32'h003, 0, 32'h8001_0000, 0, 0, 0,    1, 0, 32'h000, 4'b1100, 0, 32'hFFFF_8001, 0, 3);
`endif

        #1;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.ctrl_outs", {25'd0, busy, mem_req, mem_we, rsp_valid, rsp_err, 2'd0}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata | mem_wdata | 32'(mem_be), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_txn(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Reset asserted between clock edges while an LW sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_op = 6'd2; req_addr = 32'h300; req_wdata = 0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("arst.pre_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("arst.in_wait", {30'd0, busy, mem_req}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.ready", 32'(req_ready), 32'd1);
        begin
            bit no_rsp = 1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (rsp_valid || busy || mem_req) no_rsp = 0;
                if (k == 1) rst_n = 1'b1;
            end
            mem_rvalid = 1'b0;
            chk("arst.no_rsp", 32'(no_rsp), 32'd1);
        end
        run_txn(tbl[0], 1'b0, "arst.after");

        for (int i = 0; i < 200; i++) begin
            vec_t v;
            logic [5:0] ops[8];
            ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd15, 6'd16, 6'd17};
            v.op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
            v.merr = ($urandom_range(0, 7) == 0);
            v.gnt_dly = $urandom_range(0, 3);
            v.rv_dly = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 19) : $urandom_range(0, 4);
            v = model(v);
            run_txn(v, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, SHALL set the number of WAIT cycles without mem_rvalid before the access aborts.
REQ-002 Ports (name direction width meaning) SHALL be, clock and reset first:
clk  in  1  sole clock; all state SHALL update on its rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core access request
req_ready  out  1  controller can accept a request
req_op  in  6  access opcode (see REQ-007)
req_addr  in  32  byte address
req_wdata  in  32  store source (rs2)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  access failed; qualified by rsp_valid
mem_req  out  1  bus request
mem_gnt  in  1  bus grant
mem_we  out  1  1 = write
mem_addr  out  32  word address, bits [1:0] = 0
mem_be  out  4  byte-lane enables
mem_wdata  out  32  lane-replicated write data
mem_rvalid  in  1  bus response/write acknowledge
mem_rdata  in  32  bus read word
mem_err  in  1  bus error; qualified by mem_rvalid
busy  out  1  state != IDLE

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-004 IDLE: req_ready=1; a handshake (req_valid & req_ready) SHALL latch op/addr/wdata and go to REQ, or go straight to RESP with err=1 for an illegal opcode or trapped misalignment.
REQ-005 REQ: mem_req=1 with stable mem_we/addr/be/wdata until mem_gnt=1, then go to WAIT; no timeout in REQ.
REQ-006 WAIT: mem_rvalid=1 SHALL go to RESP capturing mem_rdata/mem_err; otherwise the cycle counter increments and reaching TIMEOUT_CYC SHALL go to RESP with err=1.
REQ-007 Opcodes SHALL be LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=15, SH=16, SW=17; every other value is illegal.
REQ-008 Byte: mem_be=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}; half: mem_be=addr[1]?4'b1100:4'b0011, mem_wdata={2{wdata[15:0]}}; word: mem_be=4'b1111, mem_wdata=wdata.
REQ-009 Loads SHALL extract the lane selected by addr, then sign-extend (LB, LH) or zero-extend (LBU, LHU); LW passes the word through.
REQ-010 Loads SHALL drive mem_we=0 and mem_be equal to the access lanes.
REQ-011 RESP: rsp_valid=1 for exactly one cycle, then IDLE; on mem_err or timeout rsp_err=1 and rsp_rdata=0.
REQ-012 Best-case latency: handshake at cycle N, mem_req at N+1, gnt at N+1, rvalid at N+2, rsp_valid at N+3.
REQ-013 mem_rvalid arriving in the same cycle the timeout expires SHALL win (normal completion).
REQ-014 mem_rvalid/mem_gnt outside REQ/WAIT SHALL be ignored.
REQ-015 busy SHALL equal (state != IDLE); req_ready SHALL equal !busy.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, clear the counter and latches, and drive every output to 0 except req_ready=1; this applies mid-access, and no response is produced for the aborted request.

Configuration
REQ-017 With MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL complete via RESP with err=1 and no bus access.
REQ-018 Without MISALIGN_TRAP_EN: offending low address bits SHALL be cleared to natural alignment, the access is issued, and err=0.

Structure
REQ-019 Opcode constants, FSM state encodings and the access-size enumeration SHALL reside in shared package lsu_pkg.
REQ-020 Lane selection and extension/replication (REQ-008/009) SHALL be a combinational sub-module lsu_align; lsu_ctrl holds the FSM, latches and timeout counter.

Verification
REQ-021 LB at addr 0x103, mem_rdata=0x80FF_1234, immediate gnt/rvalid -> rsp_valid at N+3, rsp_rdata=0xFFFF_FF80, err=0.
REQ-022 SH at addr 0x202, wdata=0x0000_ABCD -> mem_we=1, mem_addr=0x200, mem_be=4'b1100, mem_wdata=0xABCD_ABCD.
REQ-023 LW with mem_gnt held low 5 cycles -> mem_req and outputs stable 5 cycles; req_ready=0 throughout.
REQ-024 LHU with no mem_rvalid, TIMEOUT_CYC=16 -> rsp_valid with err=1, rdata=0 after 16 WAIT cycles; rvalid on the 16th cycle -> err=0.
REQ-025 LW at addr 0x101: with MISALIGN_TRAP_EN -> err=1 at N+1, mem_req never asserted; without -> mem_addr=0x100, be=4'b1111.
REQ-026 rst_n pulsed low during WAIT -> outputs reset asynchronously, no rsp_valid, next request served normally.
